conv_window_3x3: RTL and testbench
==================================

Name: conv_window_3x3

Overview:
Window generator directly upstream of the 3x3 MAC stage. It accepts a raster-order stream of unsigned 8-bit pixels, one pixel per valid beat, and buffers the two previous image rows. For every pixel position whose full 3x3 neighbourhood lies inside the image (valid convolution, no padding), it presents that neighbourhood as nine parallel bytes with a single-cycle out_valid. Its outputs connect 1:1 to the MAC's in_valid/win00..win22 inputs.

Parameters:
IMG_W, 28, image width in pixels (≥3)
IMG_H, 28, image height in pixels (≥3)
DATA_W, 8, pixel width; the MAC expects 8

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_pixel carries the next raster pixel this cycle; no backpressure
in_pixel  input  DATA_W  unsigned pixel
out_valid  output  1  window outputs valid this cycle (single-cycle pulse per window)
win00..win22  output  DATA_W each  3x3 window; winRC = pixel (r-2+R, c-2+C) for window anchored at current pixel (r,c)
frame_done  output  1  1-cycle pulse, asserted with the last window of a frame

Behaviour:
- Reset (rst=1 at a clk edge): col/row counters=0, state=FILL, out_valid=0, frame_done=0, all win*=0, window shift registers=0. Line-buffer storage is not cleared; stale content is never exposed because STREAM is only re-entered after two full rows are rewritten.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1, width $clog2 of each. They advance only on in_valid beats. col wraps at IMG_W-1 and increments row; at (IMG_H-1, IMG_W-1), both wrap to 0 (next frame starts immediately, no idle cycle needed).
- Storage: two row buffers of IMG_W entries (line1 = row r-1, line2 = row r-2), indexed by col. On each beat: read line1[col], line2[col]; write line2[col]<=line1[col], line1[col]<=in_pixel. Three 3-deep column shift registers form the window; the new column is {line2[col], line1[col], in_pixel} entering at C=2.
- in_valid=0 cycles: counters, buffers, and window registers hold; out_valid=0; win* hold their last values.
- FSM: FILL (row<2) -> STREAM on the beat that completes col IMG_W-1 of row 1; STREAM -> FILL on the beat that completes the final frame pixel; rst -> FILL from any state.
- Emission: on a beat with state==STREAM (row≥2) and col≥2, register the window and drive out_valid=1 on the next cycle (latency 1 clk from the completing in_pixel beat). Beats with col<2 update the shift registers but do not emit, so no window wraps across rows.
- Count per frame: exactly (IMG_W-2)*(IMG_H-2) out_valid pulses.
- frame_done=1 in the same cycle as the out_valid for window (IMG_H-1, IMG_W-1); otherwise 0.
- Back-to-back in_valid: one window per cycle sustained in STREAM; no bubbles are inserted.
- Reset asserted mid-frame: takes effect at that edge; the next in_valid beat is treated as pixel (0,0); no window from the aborted frame appears after reset.
- Pixels are passed through unmodified (unsigned, no arithmetic); the MAC does the zero-extension.

Test Plan:
- IMG_W=IMG_H=4, pixels 0..15 back-to-back -> 4 out_valid pulses on the cycles after pixels 10,11,14,15; first window win00..win22 = 0,1,2,4,5,6,8,9,10; last = 5,6,7,9,10,11,13,14,15 with frame_done=1.
- Same stream with in_valid deasserted every other cycle -> identical window values and count; out_valid never held >1 cycle; outputs hold during gaps.
- Two consecutive 4x4 frames (second = 100..115), no idle between -> 8 windows; first window of frame 2 = 100,101,102,104,105,106,108,109,110; no window mixes frames; frame_done pulses twice.
- rst pulsed after pixel 9 of frame 1, then frame 100..115 -> all outputs 0 after reset; only frame-2 windows emitted (4), with correct values.
- IMG_W=28, IMG_H=28, all pixels 255 -> 676 windows, all win*=255; frame_done is asserted once, on the 676th.
- Pixel value = row*16+col pattern, IMG_W=8, IMG_H=5 -> 18 windows; each winRC equals (r-2+R)*16+(c-2+C), checked by scoreboard.

Source files
------------

// File: rtl/conv_window_3x3_if.sv
// Pixel-stream in / 3x3 window out bundle between the window generator and the MAC stage.
// The producer of pixels uses the master modport; the window generator uses slave.
interface conv_window_3x3_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_pixel;
   logic              out_valid;
   logic [DATA_W-1:0] win00, win01, win02;
   logic [DATA_W-1:0] win10, win11, win12;
   logic [DATA_W-1:0] win20, win21, win22;
   logic              frame_done;

   modport master (
      output in_valid, in_pixel,
      input  out_valid, frame_done,
      input  win00, win01, win02, win10, win11, win12, win20, win21, win22
   );

   modport slave (
      input  in_valid, in_pixel,
      output out_valid, frame_done,
      output win00, win01, win02, win10, win11, win12, win20, win21, win22
   );
endinterface

// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a column shift register turn a raster
// pixel stream into valid-convolution neighbourhoods (no padding), one window per beat.
module conv_window_3x3 #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   conv_window_3x3_if.slave   bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic {FILL, STREAM} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] line1 [IMG_W];
   logic [DATA_W-1:0] line2 [IMG_W];
   logic [DATA_W-1:0] sh_p0 [3][2];
   logic [DATA_W-1:0] win_nxt [3][3];
   logic [DATA_W-1:0] win_p1 [3][3];
   logic              vld_p1, done_p1;
   logic              beat, col_end, frame_end, emit;

   assign beat      = bus.in_valid;
   assign col_end   = (col == COL_LAST);
   assign frame_end = col_end && (row == ROW_LAST);
   // state==STREAM implies row>=2, so only the column test is left to suppress row-wrapping windows
   assign emit      = beat && (state == STREAM) && (col >= CW'(2));

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (beat && col_end && (row == RW'(1))) state_nxt = STREAM;
         STREAM:  if (beat && frame_end)                  state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         if (col_end) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Line buffers are never cleared: rows 0 and 1 of each frame overwrite them before STREAM
   always_ff @(posedge clk) begin
      if (beat) begin
         line2[col] <= line1[col];
         line1[col] <= bus.in_pixel;
      end
   end

   // Stage p0: window as it looks after this beat's column has shifted in at C=2
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt[r][0] = sh_p0[r][0];
         win_nxt[r][1] = sh_p0[r][1];
         win_nxt[r][2] = '0;
      end
      win_nxt[0][2] = line2[col];
      win_nxt[1][2] = line1[col];
      win_nxt[2][2] = bus.in_pixel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            sh_p0[r][0] <= '0;
            sh_p0[r][1] <= '0;
         end
      end else if (beat) begin
         for (int r = 0; r < 3; r++) begin
            sh_p0[r][0] <= win_nxt[r][1];
            sh_p0[r][1] <= win_nxt[r][2];
         end
      end
   end

   // Stage p1: registered window, held until the next emitting beat
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_p1[r][c] <= '0;
      end else begin
         vld_p1  <= emit;
         done_p1 <= emit && frame_end;
         if (emit) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  win_p1[r][c] <= win_nxt[r][c];
         end
      end
   end

   assign bus.out_valid  = vld_p1;
   assign bus.frame_done = done_p1;
   assign bus.win00 = win_p1[0][0];
   assign bus.win01 = win_p1[0][1];
   assign bus.win02 = win_p1[0][2];
   assign bus.win10 = win_p1[1][0];
   assign bus.win11 = win_p1[1][1];
   assign bus.win12 = win_p1[1][2];
   assign bus.win20 = win_p1[2][0];
   assign bus.win21 = win_p1[2][1];
   assign bus.win22 = win_p1[2][2];
endmodule

// File: tb/tb_conv_window_3x3.sv
// Bench for conv_window_3x3: three sized instances (4x4, 28x28, 8x5) driven from a pixel table,
// outputs compared against windows computed directly from the image array.
module tb_conv_window_3x3;
   typedef struct packed {
      logic [71:0] w;
      logic        fd;
      int          t;
   } win_t;

   logic clk, rst;
   logic drv_valid;
   logic [7:0] drv_pixel;
   int   sel;
   int   cyc;
   int   tests_run, tests_failed;
   int   pix   [2048];
   int   stamp [2048];
   win_t exp_q [$];
   win_t cap   [$];
   int   dbl_cnt, hold_viol;
   logic [71:0] prev_w;
   logic        prev_v;
   logic [71:0] wa, wb, wc;

   conv_window_3x3_if #(.DATA_W(8)) if_a ();
   conv_window_3x3_if #(.DATA_W(8)) if_b ();
   conv_window_3x3_if #(.DATA_W(8)) if_c ();

   conv_window_3x3 #(.IMG_W(4),  .IMG_H(4),  .DATA_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   conv_window_3x3 #(.IMG_W(28), .IMG_H(28), .DATA_W(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   conv_window_3x3 #(.IMG_W(8),  .IMG_H(5),  .DATA_W(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   assign if_a.in_valid = drv_valid && (sel == 0);
   assign if_b.in_valid = drv_valid && (sel == 1);
   assign if_c.in_valid = drv_valid && (sel == 2);
   assign if_a.in_pixel = drv_pixel;
   assign if_b.in_pixel = drv_pixel;
   assign if_c.in_pixel = drv_pixel;

   assign wa = {if_a.win00, if_a.win01, if_a.win02, if_a.win10, if_a.win11, if_a.win12, if_a.win20, if_a.win21, if_a.win22};
   assign wb = {if_b.win00, if_b.win01, if_b.win02, if_b.win10, if_b.win11, if_b.win12, if_b.win20, if_b.win21, if_b.win22};
   assign wc = {if_c.win00, if_c.win01, if_c.win02, if_c.win10, if_c.win11, if_c.win12, if_c.win20, if_c.win21, if_c.win22};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every presented window of the selected instance, stamped with the cycle it appeared
   always @(negedge clk) begin
      logic [71:0] cw;
      logic        cv, cf;
      cw = (sel == 0) ? wa : (sel == 1) ? wb : wc;
      cv = (sel == 0) ? if_a.out_valid : (sel == 1) ? if_b.out_valid : if_c.out_valid;
      cf = (sel == 0) ? if_a.frame_done : (sel == 1) ? if_b.frame_done : if_c.frame_done;
      if (cv) cap.push_back('{w: cw, fd: cf, t: cyc});
      if (cv && prev_v) dbl_cnt++;
      if (!cv && (cw !== prev_w)) hold_viol++;
      prev_w = cw;
      prev_v = cv;
   end

   // Drive pix[start..start+n-1]; gap 0 = back-to-back, 1 = idle before every beat, 2 = random idles
   task automatic send(input int start, input int n, input int gap);
      for (int i = start; i < start + n; i++) begin
         int g;
         g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
         if (g > 0) begin
            drv_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
         drv_valid = 1'b1;
         drv_pixel = 8'(pix[i]);
         stamp[i]  = cyc + 1;
         @(posedge clk); #1;
      end
      drv_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   // Reference: every interior pixel (r,c) of each frame yields its 3x3 neighbourhood one cycle after its beat
   task automatic expect_frames(input int start, input int nframes, input int w, input int h);
      exp_q.delete();
      for (int f = 0; f < nframes; f++) begin
         int base;
         base = start + f * w * h;
         for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) begin
               win_t e;
               e.w = '0;
               for (int rr = 0; rr < 3; rr++)
                  for (int cc = 0; cc < 3; cc++)
                     e.w = {e.w[63:0], 8'(pix[base + (r - 2 + rr) * w + (c - 2 + cc)])};
               e.fd = (r == h - 1) && (c == w - 1);
               e.t  = stamp[base + r * w + c];
               exp_q.push_back(e);
            end
      end
   endtask

   task automatic select(input int s);
      sel = s;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      tests_run++;
      if ({if_a.out_valid, if_a.frame_done, wa} !== 74'd0) begin
         tests_failed++;
         $display("FAIL reset_a got vld=%b fd=%b w=%h required all zero", if_a.out_valid, if_a.frame_done, wa);
      end
      tests_run++;
      if ({if_b.out_valid, if_b.frame_done, wb} !== 74'd0) begin
         tests_failed++;
         $display("FAIL reset_b got vld=%b fd=%b w=%h required all zero", if_b.out_valid, if_b.frame_done, wb);
      end
      tests_run++;
      if ({if_c.out_valid, if_c.frame_done, wc} !== 74'd0) begin
         tests_failed++;
         $display("FAIL reset_c got vld=%b fd=%b w=%h required all zero", if_c.out_valid, if_c.frame_done, wc);
      end
   endtask

   task automatic test_basic();
      int c0;
      select(0);
      for (int i = 0; i < 16; i++) pix[i] = i;
      c0 = cap.size();
      send(0, 16, 0);
      expect_frames(0, 1, 4, 4);
      tests_run++;
      if (cap.size() - c0 !== exp_q.size()) begin
         tests_failed++;
         $display("FAIL basic_count got %0d required %0d", cap.size() - c0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         tests_run++;
         if (cap[c0 + i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL basic_win%0d got w=%h fd=%b t=%0d required w=%h fd=%b t=%0d", i,
                     cap[c0 + i].w, cap[c0 + i].fd, cap[c0 + i].t, exp_q[i].w, exp_q[i].fd, exp_q[i].t);
         end
      end
   endtask

   task automatic test_gaps();
      int c0, d0, h0;
      select(0);
      for (int i = 0; i < 16; i++) pix[i] = i;
      c0 = cap.size(); d0 = dbl_cnt; h0 = hold_viol;
      send(0, 16, 1);
      expect_frames(0, 1, 4, 4);
      tests_run++;
      if (cap.size() - c0 !== exp_q.size()) begin
         tests_failed++;
         $display("FAIL gaps_count got %0d required %0d", cap.size() - c0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         tests_run++;
         if (cap[c0 + i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL gaps_win%0d got w=%h fd=%b t=%0d required w=%h fd=%b t=%0d", i,
                     cap[c0 + i].w, cap[c0 + i].fd, cap[c0 + i].t, exp_q[i].w, exp_q[i].fd, exp_q[i].t);
         end
      end
      tests_run++;
      if (dbl_cnt - d0 !== 0) begin
         tests_failed++;
         $display("FAIL gaps_pulse_width got %0d multi-cycle pulses required 0", dbl_cnt - d0);
      end
      tests_run++;
      if (hold_viol - h0 !== 0) begin
         tests_failed++;
         $display("FAIL gaps_hold got %0d window changes without out_valid required 0", hold_viol - h0);
      end
   endtask

   task automatic test_back_to_back();
      int c0, nfd;
      select(0);
      for (int i = 0; i < 16; i++) begin pix[i] = i; pix[16 + i] = 100 + i; end
      c0 = cap.size();
      send(0, 32, 0);
      expect_frames(0, 2, 4, 4);
      tests_run++;
      if (cap.size() - c0 !== exp_q.size()) begin
         tests_failed++;
         $display("FAIL b2b_count got %0d required %0d", cap.size() - c0, exp_q.size());
      end
      nfd = 0;
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         if (cap[c0 + i].fd) nfd++;
         tests_run++;
         if (cap[c0 + i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL b2b_win%0d got w=%h fd=%b t=%0d required w=%h fd=%b t=%0d", i,
                     cap[c0 + i].w, cap[c0 + i].fd, cap[c0 + i].t, exp_q[i].w, exp_q[i].fd, exp_q[i].t);
         end
      end
      tests_run++;
      if (nfd !== 2) begin
         tests_failed++;
         $display("FAIL b2b_frame_done got %0d pulses required 2", nfd);
      end
   endtask

   task automatic test_mid_reset();
      int c0;
      select(0);
      for (int i = 0; i < 16; i++) begin pix[i] = i; pix[16 + i] = 100 + i; end
      c0 = cap.size();
      send(0, 10, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests_run++;
      if ({if_a.out_valid, if_a.frame_done, wa} !== 74'd0) begin
         tests_failed++;
         $display("FAIL midrst_zero got vld=%b fd=%b w=%h required all zero", if_a.out_valid, if_a.frame_done, wa);
      end
      send(16, 16, 0);
      expect_frames(16, 1, 4, 4);
      tests_run++;
      if (cap.size() - c0 !== exp_q.size()) begin
         tests_failed++;
         $display("FAIL midrst_count got %0d required %0d", cap.size() - c0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         tests_run++;
         if (cap[c0 + i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL midrst_win%0d got w=%h fd=%b t=%0d required w=%h fd=%b t=%0d", i,
                     cap[c0 + i].w, cap[c0 + i].fd, cap[c0 + i].t, exp_q[i].w, exp_q[i].fd, exp_q[i].t);
         end
      end
   endtask

   task automatic test_full_255();
      int c0, bad, nfd;
      select(1);
      for (int i = 0; i < 784; i++) pix[i] = 255;
      c0 = cap.size();
      send(0, 784, 0);
      expect_frames(0, 1, 28, 28);
      tests_run++;
      if (cap.size() - c0 !== 676) begin
         tests_failed++;
         $display("FAIL full255_count got %0d required 676", cap.size() - c0);
      end
      bad = 0; nfd = 0;
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         if (cap[c0 + i] !== exp_q[i]) bad++;
         if (cap[c0 + i].fd) nfd++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL full255_windows got %0d wrong windows required 0", bad);
      end
      tests_run++;
      if (nfd !== 1 || !(cap.size() > c0 + 675 && cap[c0 + 675].fd)) begin
         tests_failed++;
         $display("FAIL full255_frame_done got %0d pulses required 1 on window 676", nfd);
      end
   endtask

   task automatic test_pattern();
      int c0;
      select(2);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 8; c++) pix[r * 8 + c] = r * 16 + c;
      c0 = cap.size();
      send(0, 40, 0);
      expect_frames(0, 1, 8, 5);
      tests_run++;
      if (cap.size() - c0 !== 18) begin
         tests_failed++;
         $display("FAIL pattern_count got %0d required 18", cap.size() - c0);
      end
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         tests_run++;
         if (cap[c0 + i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL pattern_win%0d got w=%h fd=%b t=%0d required w=%h fd=%b t=%0d", i,
                     cap[c0 + i].w, cap[c0 + i].fd, cap[c0 + i].t, exp_q[i].w, exp_q[i].fd, exp_q[i].t);
         end
      end
   endtask

   task automatic test_random();
      int c0;
      select(2);
      for (int i = 0; i < 80; i++) pix[i] = int'($urandom_range(0, 255));
      c0 = cap.size();
      send(0, 80, 2);
      expect_frames(0, 2, 8, 5);
      tests_run++;
      if (cap.size() - c0 !== exp_q.size()) begin
         tests_failed++;
         $display("FAIL random_count got %0d required %0d", cap.size() - c0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && c0 + i < cap.size(); i++) begin
         tests_run++;
         if (cap[c0 + i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL random_win%0d got w=%h fd=%b t=%0d required w=%h fd=%b t=%0d", i,
                     cap[c0 + i].w, cap[c0 + i].fd, cap[c0 + i].t, exp_q[i].w, exp_q[i].fd, exp_q[i].t);
         end
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      dbl_cnt = 0; hold_viol = 0;
      prev_w = '0; prev_v = 1'b0;
      sel = 0;
      rst = 1'b1;
      drv_valid = 1'b0;
      drv_pixel = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      test_full_255();
      test_pattern();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
